// File: rtl/svm_feeder_pkg.sv
// Shared definitions for the svm feeder: widths, config map and FSM state encoding.
// Fixed-point formats seen by the core: alpha Q4.11, weight Q0.15 signed, sample components Q2.13 signed.
package svm_feeder_pkg;

    localparam int N_SVS       = 6;
    localparam int ALPHA_BW    = 16;
    localparam int WEIGHT_BW   = 16;
    localparam int DATA_BW     = 16;
    localparam int ADDR_BW     = 4;
    localparam int CFG_DATA_BW = 16;

    localparam logic [ADDR_BW-1:0] CFG_ADDR_ALPHA = '0;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_ALPHA  = 3'd2;
    localparam state_t ST_WEIGHT = 3'd3;
    localparam state_t ST_STREAM = 3'd4;
    localparam state_t ST_DONE   = 3'd5;

    typedef struct packed {
        state_t              state;
        logic [ADDR_BW-1:0]  wcnt;
    } svm_feeder_dbg_t;

endpackage

// File: rtl/svm_feeder_if.sv
// Host/core-facing bundle of the svm feeder: config port, run request, sample stream, core load pins.
// Sample handshake: a beat transfers on a rising clock edge where s_valid and s_ready are both high;
// s_x/s_y/s_last must be stable while s_valid is high, and s_ready never depends on s_valid.
interface svm_feeder_if;
    import svm_feeder_pkg::*;

    logic                   cfg_we;
    logic [ADDR_BW-1:0]     cfg_addr;
    logic [CFG_DATA_BW-1:0] cfg_data;
    logic                   run;
    logic                   s_valid;
    logic                   s_ready;
    logic [DATA_BW-1:0]     s_x;
    logic [DATA_BW-1:0]     s_y;
    logic                   s_last;
    logic                   start;
    logic [ALPHA_BW-1:0]    alpha;
    logic [WEIGHT_BW-1:0]   weight;
    logic                   de_in;
    logic [DATA_BW-1:0]     data_x;
    logic [DATA_BW-1:0]     data_y;
    logic                   busy;
    logic                   done;

    modport master (
        output cfg_we, cfg_addr, cfg_data, run, s_valid, s_x, s_y, s_last,
        input  s_ready, start, alpha, weight, de_in, data_x, data_y, busy, done
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, run, s_valid, s_x, s_y, s_last,
        output s_ready, start, alpha, weight, de_in, data_x, data_y, busy, done
    );

endinterface

// File: rtl/svm_feeder_param_bank.sv
// Alpha plus weight register file: synchronous write, asynchronous read by weight index.
module svm_feeder_param_bank
    import svm_feeder_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   we_i,
    input  logic [ADDR_BW-1:0]     waddr_i,
    input  logic [CFG_DATA_BW-1:0] wdata_i,
    input  logic [ADDR_BW-1:0]     ridx_i,
    output logic [ALPHA_BW-1:0]    alpha_o,
    output logic [WEIGHT_BW-1:0]   weight_o
);

    logic [ALPHA_BW-1:0]  alpha_q;
    logic [WEIGHT_BW-1:0] w_q [N_SVS];

    // Addresses above N_SVS match no entry and are silently dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alpha_q <= '0;
            for (int i = 0; i < N_SVS; i++) begin
                w_q[i] <= '0;
            end
        end else if (we_i) begin
            if (waddr_i == CFG_ADDR_ALPHA) begin
                alpha_q <= wdata_i[ALPHA_BW-1:0];
            end
            for (int i = 0; i < N_SVS; i++) begin
                if (waddr_i == ADDR_BW'(i + 1)) begin
                    w_q[i] <= wdata_i[WEIGHT_BW-1:0];
                end
            end
        end
    end

    always_comb begin
        weight_o = '0;
        for (int i = 0; i < N_SVS; i++) begin
            if (ridx_i == ADDR_BW'(i)) begin
                weight_o = w_q[i];
            end
        end
    end

    assign alpha_o = alpha_q;

endmodule

// File: rtl/svm_feeder.sv
// Sequencer replaying the svm core load protocol: start, alpha, weights, then a DE_in-qualified sample stream.
module svm_feeder
    import svm_feeder_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    svm_feeder_if.slave     bus,
    output svm_feeder_dbg_t dbg_o
);

    localparam logic [ADDR_BW-1:0] CNT_LAST = ADDR_BW'(N_SVS - 1);

    state_t               state_q, state_d;
    logic [ADDR_BW-1:0]   cnt_q, cnt_d;
    logic                 accept;
    logic                 bank_we;
    logic [ALPHA_BW-1:0]  bank_alpha;
    logic [WEIGHT_BW-1:0] bank_weight;

    logic                 start_q;
    logic [ALPHA_BW-1:0]  alpha_q;
    logic [WEIGHT_BW-1:0] weight_q;
    logic                 de_q;
    logic [DATA_BW-1:0]   data_x_q, data_y_q;
    logic                 done_q;

    assign accept  = (state_q == ST_STREAM) && bus.s_valid;
    assign bank_we = (state_q == ST_IDLE) && bus.cfg_we;

    svm_feeder_param_bank u_bank (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .we_i     (bank_we),
        .waddr_i  (bus.cfg_addr),
        .wdata_i  (bus.cfg_data),
        .ridx_i   (cnt_d),
        .alpha_o  (bank_alpha),
        .weight_o (bank_weight)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE:   if (bus.run) state_d = ST_START;
            ST_START:  state_d = ST_ALPHA;
            ST_ALPHA: begin
                state_d = ST_WEIGHT;
                cnt_d   = '0;
            end
            ST_WEIGHT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_STREAM;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_BW'(1);
                end
            end
            ST_STREAM: if (accept && bus.s_last) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pins are registered from the next state so each pin tracks the state it belongs to.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            start_q  <= 1'b0;
            alpha_q  <= '0;
            weight_q <= '0;
            de_q     <= 1'b0;
            data_x_q <= '0;
            data_y_q <= '0;
            done_q   <= 1'b0;
        end else begin
            start_q  <= (state_d != ST_IDLE);
            alpha_q  <= bank_alpha;
            weight_q <= (state_d == ST_WEIGHT) ? bank_weight : '0;
            de_q     <= accept;
            if (accept) begin
                data_x_q <= bus.s_x;
                data_y_q <= bus.s_y;
            end
            done_q   <= (state_d == ST_DONE);
        end
    end

    assign bus.s_ready = (state_q == ST_STREAM);
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.start   = start_q;
    assign bus.alpha   = alpha_q;
    assign bus.weight  = weight_q;
    assign bus.de_in   = de_q;
    assign bus.data_x  = data_x_q;
    assign bus.data_y  = data_y_q;
    assign bus.done    = done_q;

    assign dbg_o = '{state: state_q, wcnt: cnt_q};

endmodule

// File: tb/tb_svm_feeder.sv
// Bench for svm_feeder: table-driven load replay, randomized sample batches and reset/back-to-back corner cases.
module tb_svm_feeder;
    import svm_feeder_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    svm_feeder_dbg_t dbg;

    svm_feeder_if bus();

    svm_feeder dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus),
        .dbg_o  (dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: bank contents, busy flag, expected beats and last driven sample.
    logic [31:0] exp_q[$];
    logic [15:0] mdl_alpha;
    logic [15:0] mdl_w [6];
    bit          mdl_busy;
    logic [15:0] mdl_x, mdl_y;
    int          de_seen = 0;
    int          done_seen = 0;
    int          de0, done0;

    typedef struct {
        logic        run;
        logic        start;
        logic        busy;
        logic        chk_alpha;
        logic [15:0] alpha;
        logic [15:0] weight;
        logic        s_ready;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void mdl_write(input int addr, input logic [15:0] d);
        if (mdl_busy) return;
        if (addr == 0) mdl_alpha = d;
        else if (addr <= 6) mdl_w[addr-1] = d;
    endfunction

    function automatic void mdl_reset();
        mdl_alpha = '0;
        for (int i = 0; i < 6; i++) mdl_w[i] = '0;
        mdl_busy = 0;
        mdl_x = '0;
        mdl_y = '0;
        exp_q.delete();
    endfunction

    // Expected load replay for cycles 0 (run sampled) .. 9 (first STREAM cycle).
    function automatic void fill_tbl(input bit keep_run);
        for (int r = 0; r < 10; r++) begin
            tbl[r].run       = (r == 0) || keep_run;
            tbl[r].start     = (r != 0);
            tbl[r].busy      = (r != 0);
            tbl[r].chk_alpha = (r >= 2);
            tbl[r].alpha     = mdl_alpha;
            tbl[r].weight    = (r >= 3 && r <= 8) ? mdl_w[r-3] : 16'h0;
            tbl[r].s_ready   = (r == 9);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            logic [31:0] e;
            logic        exp_de;
            exp_de = (exp_q.size() != 0);
            chk("de_in", 32'(bus.de_in), 32'(exp_de));
            if (bus.de_in && exp_de) begin
                e = exp_q.pop_front();
                chk("data_x", 32'(bus.data_x), 32'(e[31:16]));
                chk("data_y", 32'(bus.data_y), 32'(e[15:0]));
                mdl_x = e[31:16];
                mdl_y = e[15:0];
            end else if (!bus.de_in) begin
                chk("data_x_hold", 32'(bus.data_x), 32'(mdl_x));
                chk("data_y_hold", 32'(bus.data_y), 32'(mdl_y));
            end
            if (bus.de_in) de_seen++;
            if (bus.done) done_seen++;
        end
    end

    task automatic cfg_write(input int addr, input logic [15:0] d);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = ADDR_BW'(addr);
        bus.cfg_data = d;
        mdl_write(addr, d);
        step();
        bus.cfg_we = 1'b0;
    endtask

    // Applies tbl from cycle 0; optional cfg write in cycle wr_cyc (0 = same cycle as run).
    task automatic replay(input bit use_model, input bit keep_run,
                          input int wr_cyc, input int wr_addr, input logic [15:0] wr_data);
        if (wr_cyc == 0) mdl_write(wr_addr, wr_data);
        if (use_model) fill_tbl(keep_run);
        for (int r = 0; r < 10; r++) begin
            bus.run = tbl[r].run;
            if (r == wr_cyc) begin
                bus.cfg_we   = 1'b1;
                bus.cfg_addr = ADDR_BW'(wr_addr);
                bus.cfg_data = wr_data;
                if (r != 0) mdl_write(wr_addr, wr_data);
            end
            @(negedge clk);
            chk($sformatf("start_c%0d", r), 32'(bus.start), 32'(tbl[r].start));
            chk($sformatf("busy_c%0d", r), 32'(bus.busy), 32'(tbl[r].busy));
            chk($sformatf("weight_c%0d", r), 32'(bus.weight), 32'(tbl[r].weight));
            chk($sformatf("s_ready_c%0d", r), 32'(bus.s_ready), 32'(tbl[r].s_ready));
            if (tbl[r].chk_alpha) chk($sformatf("alpha_c%0d", r), 32'(bus.alpha), 32'(tbl[r].alpha));
            if (r == 0) mdl_busy = 1;
            if (r < 9) begin
                step();
                bus.cfg_we = 1'b0;
            end
        end
        bus.cfg_we = 1'b0;
    endtask

    // gap_mode: 0 back-to-back, 1 every other cycle, 2 random 0..2 idle cycles.
    task automatic stream_beats(input int n, input int gap_mode, input bit last_on_final);
        de0   = de_seen;
        done0 = done_seen;
        for (int i = 0; i < n; i++) begin
            logic [15:0] x, y;
            if (i > 0) begin
                int g;
                g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
                repeat (g) step();
            end
            x = 16'($urandom);
            y = 16'($urandom);
            bus.s_valid = 1'b1;
            bus.s_x     = x;
            bus.s_y     = y;
            bus.s_last  = last_on_final && (i == n - 1);
            #1;
            chk("s_ready_beat", 32'(bus.s_ready), 32'd1);
            step();
            bus.s_valid = 1'b0;
            bus.s_last  = 1'b0;
            exp_q.push_back({x, y});
        end
    endtask

    // Checks the DONE cycle and the IDLE cycle after it; returns at the drive point of the next cycle.
    task automatic finish_batch(input int n);
        @(negedge clk);
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("busy_in_done", 32'(bus.busy), 32'd1);
        chk("s_ready_in_done", 32'(bus.s_ready), 32'd0);
        mdl_busy = 0;
        step();
        @(negedge clk);
        chk("done_low", 32'(bus.done), 32'd0);
        chk("busy_idle", 32'(bus.busy), 32'd0);
        chk("start_idle", 32'(bus.start), 32'd0);
        chk("s_ready_idle", 32'(bus.s_ready), 32'd0);
        chk("de_count", 32'(de_seen - de0), 32'(n));
        chk("done_count", 32'(done_seen - done0), 32'd1);
        step();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_start"}, 32'(bus.start), 32'd0);
        chk({tag, "_alpha"}, 32'(bus.alpha), 32'd0);
        chk({tag, "_weight"}, 32'(bus.weight), 32'd0);
        chk({tag, "_de_in"}, 32'(bus.de_in), 32'd0);
        chk({tag, "_data_x"}, 32'(bus.data_x), 32'd0);
        chk({tag, "_data_y"}, 32'(bus.data_y), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_s_ready"}, 32'(bus.s_ready), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_data = '0; bus.run = 0;
        bus.s_valid = 0; bus.s_x = '0; bus.s_y = '0; bus.s_last = 0;
        mdl_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        #2 rst_n = 1'b1;
        step();

        // Load alpha=0800, weights 1..6 and replay against a constant table
        cfg_write(0, 16'h0800);
        for (int k = 1; k <= 6; k++) cfg_write(k, 16'(k));
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0800, 16'h0000, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0800, 16'h0000, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0800, 16'h0001, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0800, 16'h0002, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0800, 16'h0003, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0800, 16'h0004, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0800, 16'h0005, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0800, 16'h0006, 1'b0};
        tbl[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0800, 16'h0000, 1'b1};
        replay(1'b0, 1'b0, -1, 0, 16'h0);
        stream_beats(4, 0, 1'b1);
        finish_batch(4);

        // Every-other-cycle valid
        replay(1'b1, 1'b0, -1, 0, 16'h0);
        stream_beats(6, 1, 1'b1);
        finish_batch(6);

        // Random bank contents, out-of-range addresses, random gaps
        for (int k = 0; k <= 6; k++) cfg_write(k, 16'($urandom));
        cfg_write(7, 16'($urandom));
        cfg_write(15, 16'($urandom));
        replay(1'b1, 1'b0, -1, 0, 16'h0);
        stream_beats(5, 2, 1'b1);
        finish_batch(5);

        // Write during WEIGHT is dropped; the same write in IDLE lands
        replay(1'b1, 1'b0, 4, 3, 16'h7FFF);
        stream_beats(2, 0, 1'b1);
        finish_batch(2);
        cfg_write(3, 16'h7FFF);
        replay(1'b1, 1'b0, -1, 0, 16'h0);
        chk("model_w3", 32'(mdl_w[2]), 32'h7FFF);
        stream_beats(1, 0, 1'b1);
        finish_batch(1);

        // Write in the same cycle as run is used by that replay
        replay(1'b1, 1'b0, 0, 1, 16'($urandom));
        stream_beats(3, 2, 1'b1);
        finish_batch(3);

        // Reset in STREAM after 2 beats
        replay(1'b1, 1'b0, -1, 0, 16'h0);
        stream_beats(2, 0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        chk("midrst_no_done", 32'(done_seen - done0), 32'd0);
        mdl_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
        step();
        replay(1'b1, 1'b0, -1, 0, 16'h0);
        stream_beats(1, 0, 1'b1);
        finish_batch(1);

        // Single-sample batch with run held high: next START two cycles after DONE
        for (int k = 0; k <= 6; k++) cfg_write(k, 16'($urandom));
        replay(1'b1, 1'b1, -1, 0, 16'h0);
        stream_beats(1, 0, 1'b1);
        @(negedge clk);
        chk("held_done", 32'(bus.done), 32'd1);
        mdl_busy = 0;
        step();
        @(negedge clk);
        chk("held_idle_busy", 32'(bus.busy), 32'd0);
        chk("held_idle_start", 32'(bus.start), 32'd0);
        chk("held_de_count", 32'(de_seen - de0), 32'd1);
        chk("held_done_count", 32'(done_seen - done0), 32'd1);
        step();
        @(negedge clk);
        chk("held_restart_start", 32'(bus.start), 32'd1);
        chk("held_restart_busy", 32'(bus.busy), 32'd1);
        mdl_busy = 1;
        step();
        bus.run = 1'b0;
        repeat (7) step();
        stream_beats(1, 0, 1'b1);
        finish_batch(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
